sha256d_miner: RTL

- Self-contained Bitcoin-style nonce scanner. Holds NUM_LANES instances of the team's sha256_core (init, next, mode, block[511:0], ready, digest[255:0], digest_valid), one per lane.
- Each lane pads an 80-byte header, runs a double SHA-256 on it, byte-reverses the result and compares it to a target.
- Lanes sweep interleaved nonces across a programmable range. Sits between the host register file and the hashing cores, and replaces the software mining loop.

---
 rtl/sha256d_miner.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sha256d_miner.sv
// sha256d_miner: Bitcoin-style double SHA-256 nonce scanner.
//   NUM_LANES lanes, each with its own sha256_core, sweep interleaved nonces
//   (lane i tests start+i, start+i+NUM_LANES, ...). Each lane hashes an 80-byte
//   header twice, byte-reverses the result and compares it with the target.
// Ports:
//   clk, reset_n (async active-low)     clock / reset (also resets the cores)
//   start, stop                         single-cycle control pulses
//   header_in[639:0]                    header; nonce field [31:0] is ignored
//   target[255:0]                       hit when reversed hash < target
//   nonce_start, nonce_end [31:0]       inclusive nonce range
//   busy, done                          scan active / one-cycle end pulse
//   found, exhausted                    result levels, held until next start
//   found_nonce[31:0], found_hash[255:0] winning nonce and its reversed hash
// Optional: define SHA256D_MINER_HASH_CTR_EN to add hash_count[47:0], a
//   saturating count of completed double hashes, cleared on an accepted start.
// Also contains sha256_core (one 64-round compression per block, 1 round/cycle).

module sha256_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic         mode,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  logic [31:0] h [8];    // chaining value
  logic [31:0] v [8];    // working variables a..h
  logic [31:0] w [16];   // sliding message schedule window, w[0] = W[t]
  logic [6:0]  round;
  logic        active;
  logic [31:0] t1, t2, w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  always_comb begin
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[round[5:0]] + w[0];
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
            + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active       <= 1'b0;
      ready        <= 1'b1;
      digest_valid <= 1'b0;
      round        <= '0;
      for (int i = 0; i < 8; i++) begin
        h[i] <= '0;
        v[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (active) begin
      if (round == 7'd64) begin
        // Extra cycle after the 64 rounds folds the working state into h.
        for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
        active       <= 1'b0;
        ready        <= 1'b1;
        digest_valid <= 1'b1;
      end else begin
        v[0] <= t1 + t2;
        v[1] <= v[0];
        v[2] <= v[1];
        v[3] <= v[2];
        v[4] <= v[3] + t1;
        v[5] <= v[4];
        v[6] <= v[5];
        v[7] <= v[6];
        for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
        w[15] <= w_new;
        round <= round + 7'd1;
      end
    end else if (init || next) begin
      for (int i = 0; i < 8; i++) begin
        if (init) begin
          h[i] <= mode ? IV256[i] : IV224[i];
          v[i] <= mode ? IV256[i] : IV224[i];
        end else begin
          v[i] <= h[i];
        end
      end
      for (int i = 0; i < 16; i++) w[i] <= block[511 - 32*i -: 32];
      round        <= '0;
      active       <= 1'b1;
      ready        <= 1'b0;
      digest_valid <= 1'b0;
    end
  end

  assign digest = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
endmodule

module sha256d_miner #(
  parameter int NUM_LANES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  input  logic [639:0] header_in,
  input  logic [255:0] target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash
`ifdef SHA256D_MINER_HASH_CTR_EN
  ,
  output logic [47:0]  hash_count
`endif
);
  typedef enum logic [2:0] {
    IDLE, H1A_INIT, H1A_WAIT, H1B_NEXT, H1B_WAIT, H2_INIT, H2_WAIT, CMP
  } lane_state_t;

  logic [639:32] hdr;      // nonce field is never stored; lanes insert their own
  logic [255:0]  tgt;
  logic [32:0]   n_end;    // 33 bits so nonce+NUM_LANES past 0xFFFFFFFF compares larger
  logic          drain;    // a hit or stop has been seen; lanes finish and idle
  logic          stopped;
  logic          accept, abort, hit_any, all_idle;
  logic [31:0]   win_nonce;
  logic [255:0]  win_hash;
  logic [3:0]    cmp_count;
  logic [NUM_LANES-1:0] lane_hit, lane_cmp, lane_idle;
  logic [31:0]   lane_nonce [NUM_LANES];
  logic [255:0]  lane_rev   [NUM_LANES];
  logic          unused_nonce_field;

  assign unused_nonce_field = ^header_in[31:0];
  assign accept   = start & ~busy;
  assign abort    = drain | (busy & stop);
  assign all_idle = &lane_idle;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_state_t  state, state_next;
    logic [32:0]  nonce, first_nonce, nonce_step;
    logic         core_init, core_next, core_ready, core_valid;
    logic [511:0] core_block;
    logic [255:0] core_digest;

    assign first_nonce = {1'b0, nonce_start} + 33'(gi);
    assign nonce_step  = nonce + 33'(NUM_LANES);

    // Byte reversal: digest byte [7:0] lands in rev[255:248].
    for (genvar b = 0; b < 32; b++) begin : g_rev
      assign lane_rev[gi][255 - 8*b -: 8] = core_digest[8*b +: 8];
    end

    assign lane_cmp[gi]   = (state == CMP);
    assign lane_idle[gi]  = (state == IDLE);
    assign lane_hit[gi]   = (state == CMP) && (lane_rev[gi] < tgt);
    assign lane_nonce[gi] = nonce[31:0];

    always_comb begin
      state_next = state;
      core_init  = 1'b0;
      core_next  = 1'b0;
      core_block = '0;
      case (state)
        IDLE:     if (accept && (first_nonce <= {1'b0, nonce_end})) state_next = H1A_INIT;
        H1A_INIT: begin
          core_init  = 1'b1;
          core_block = hdr[639:128];
          state_next = H1A_WAIT;
        end
        H1A_WAIT: if (core_ready && core_valid) state_next = abort ? IDLE : H1B_NEXT;
        H1B_NEXT: begin
          core_next  = 1'b1;
          core_block = {hdr[127:32], nonce[31:0], 1'b1, 319'b0, 64'd640};
          state_next = H1B_WAIT;
        end
        H1B_WAIT: if (core_ready && core_valid) state_next = abort ? IDLE : H2_INIT;
        H2_INIT: begin
          // The core still holds the first hash while init is presented.
          core_init  = 1'b1;
          core_block = {core_digest, 1'b1, 191'b0, 64'd256};
          state_next = H2_WAIT;
        end
        H2_WAIT:  if (core_ready && core_valid) state_next = abort ? IDLE : CMP;
        CMP:      state_next = (hit_any || abort || (nonce_step > n_end)) ? IDLE : H1A_INIT;
        default:  state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= IDLE;
        nonce <= '0;
      end else begin
        state <= state_next;
        if (accept)             nonce <= first_nonce;
        else if (state == CMP)  nonce <= nonce_step;
      end
    end

    sha256_core core (
      .clk(clk), .reset_n(reset_n), .init(core_init), .next(core_next), .mode(1'b1),
      .block(core_block), .ready(core_ready), .digest(core_digest), .digest_valid(core_valid)
    );
  end

  // Lowest lane index wins; lanes are in lockstep so it also holds the lowest nonce.
  always_comb begin
    hit_any   = 1'b0;
    win_nonce = '0;
    win_hash  = '0;
    cmp_count = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_hit[i]) begin
        hit_any   = 1'b1;
        win_nonce = lane_nonce[i];
        win_hash  = lane_rev[i];
      end
      cmp_count = cmp_count + {3'b0, lane_cmp[i]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;  done <= 1'b0;  found <= 1'b0;  exhausted <= 1'b0;
      found_nonce <= '0;  found_hash <= '0;
      hdr <= '0;  tgt <= '0;  n_end <= '0;  drain <= 1'b0;  stopped <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        hdr       <= header_in[639:32];
        tgt       <= target;
        n_end     <= {1'b0, nonce_end};
        found     <= 1'b0;
        exhausted <= 1'b0;
        drain     <= 1'b0;
        stopped   <= 1'b0;
        busy      <= 1'b1;
      end else if (busy) begin
        if (stop) begin
          drain   <= 1'b1;
          stopped <= 1'b1;
        end
        if (hit_any && !abort) begin
          found       <= 1'b1;
          found_nonce <= win_nonce;
          found_hash  <= win_hash;
          drain       <= 1'b1;
        end
        if (all_idle) begin
          busy      <= 1'b0;
          done      <= 1'b1;
          exhausted <= !found && !stopped;
        end
      end
    end
  end

`ifdef SHA256D_MINER_HASH_CTR_EN
  logic [48:0] hc_sum;
  assign hc_sum = {1'b0, hash_count} + {45'b0, cmp_count};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    hash_count <= '0;
    else if (accept) hash_count <= '0;
    else             hash_count <= hc_sum[48] ? '1 : hc_sum[47:0];
  end
`else
  logic unused_cmp_count;
  assign unused_cmp_count = ^cmp_count;
`endif
endmodule
